fetch_unit: RTL

- Parametrised instruction-fetch front end for the network-loaded core.
- Owns the PC and issues reads to a 1-cycle-latency instruction memory.
- Buffers fetched instructions in a FIFO and hands them to decode over a valid/ready handshake.
- Replaces fixed single-slot NOP insertion: after handing off a control-flow instruction, it stops fetching until the branch resolves, then resumes at the resolved target.

---
 rtl/fetch_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues 1-cycle imem reads, buffers
// responses in a small FIFO and stops fetching after a control-flow handoff.
module fetch_unit #(
  parameter int imem_addr_width_p = 10,
  parameter int instr_width_p     = 16,
  parameter int fifo_depth_p      = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start_v_i,
  input  logic [imem_addr_width_p-1:0]       start_pc_i,
  input  logic                               imem_busy_i,
  output logic                               imem_v_o,
  output logic [imem_addr_width_p-1:0]       imem_addr_o,
  input  logic [instr_width_p-1:0]           imem_data_i,
  output logic                               instr_v_o,
  output logic [instr_width_p-1:0]           instr_o,
  output logic [imem_addr_width_p-1:0]       instr_pc_o,
  input  logic                               instr_ready_i,
  input  logic                               instr_is_cf_i,
  input  logic                               resolve_v_i,
  input  logic                               redirect_v_i,
  input  logic [imem_addr_width_p-1:0]       redirect_pc_i,
  output logic [1:0]                         state_o,
  output logic                               err_o,
  output logic [$clog2(fifo_depth_p):0]      count_o
);

  localparam int AW   = imem_addr_width_p;
  localparam int IW   = instr_width_p;
  localparam int PtrW = $clog2(fifo_depth_p);
  localparam int CntW = PtrW + 1;
  localparam int OccW = CntW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WAIT_CF = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [AW-1:0]     resume_pc_q, resume_pc_d;
  logic [AW-1:0]     issue_pc_q;
  logic              inflight_q;
  logic              err_q, err_d;
  logic [IW-1:0]     instr_mem_q [fifo_depth_p];
  logic [AW-1:0]     pc_mem_q    [fifo_depth_p];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  logic              head_v, pop, push, cf_hs;
  logic [OccW-1:0]   occ;
  logic [AW-1:0]     head_pc;

  assign head_v  = (count_q != '0);
  assign head_pc = pc_mem_q[rd_ptr_q];
  assign pop     = head_v & instr_ready_i;
  assign cf_hs   = (state_q == RUN) & pop & instr_is_cf_i;
  // A control-flow handoff drops whatever response is arriving this cycle.
  assign push    = inflight_q & ~cf_hs;
  assign occ     = {1'b0, count_q} + OccW'(inflight_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_v_i)   state_d = RUN;
      RUN:     if (cf_hs)       state_d = WAIT_CF;
      WAIT_CF: if (resolve_v_i) state_d = RUN;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_v_o = (state_q == RUN) & ~imem_busy_i & (occ < OccW'(fifo_depth_p)) & ~cf_hs;
  end

  always_comb begin
    pc_d        = pc_q;
    resume_pc_d = resume_pc_q;
    err_d       = err_q | (start_v_i & (state_q != IDLE));
    if ((state_q == IDLE) && start_v_i)
      pc_d = start_pc_i;
    else if ((state_q == WAIT_CF) && resolve_v_i)
      pc_d = redirect_v_i ? redirect_pc_i : resume_pc_q;
    else if (imem_v_o)
      pc_d = pc_q + AW'(1);
    if (cf_hs)
      resume_pc_d = head_pc + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= imem_v_o;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    resume_pc_q <= resume_pc_d;
    if (imem_v_o) issue_pc_q <= pc_q;
  end

  // FIFO control; a flush resets both pointers so the buffer restarts empty.
  always_ff @(posedge clk) begin
    if (reset || cf_hs) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_mem_q[wr_ptr_q] <= imem_data_i;
      pc_mem_q[wr_ptr_q]    <= issue_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && !pop && (count_q == CntW'(fifo_depth_p))));
  end

  assign imem_addr_o = pc_q;
  assign instr_v_o   = head_v;
  assign instr_o     = head_v ? instr_mem_q[rd_ptr_q] : '0;
  assign instr_pc_o  = head_v ? head_pc : '0;
  assign state_o     = state_q;
  assign err_o       = err_q;
  assign count_o     = count_q;

endmodule
